// File: rtl/conveng_pixel_server_pkg.sv
// Shared types and constants for the conveng pixel server.
//   PixBits/PixPerWord/WordBits : pixel and packed-word geometry
//   state_e                     : fill-state FSM encoding
//   put_lane()                  : replace one 8-bit lane of a packed word
package conveng_pixel_server_pkg;

  localparam int unsigned PixBits    = 8;
  localparam int unsigned PixPerWord = 8;
  localparam int unsigned WordBits   = PixBits * PixPerWord;
  localparam int unsigned LaneBits   = $clog2(PixPerWord);
  localparam int unsigned ReqAddrW   = 32;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StReady
  } state_e;

  function automatic logic [WordBits-1:0] put_lane(input logic [WordBits-1:0] word,
                                                   input logic [LaneBits-1:0] lane,
                                                   input logic [PixBits-1:0]  pix);
    logic [WordBits-1:0] w;
    w = word;
    w[lane*PixBits +: PixBits] = pix;
    return w;
  endfunction

endpackage

// File: rtl/conveng_pixel_server_if.sv
// Pixel stream + word-read bundle between the stream/request source (master)
// and the pixel server (slave).
//   newFrame, iValid, iR/iG/iB      : pixel stream in
//   iReq, iRdAddress, oReqReady     : read-request handshake
//   orData/ogData/obData, oRdValid  : read response
//   oFrameReady, oOverflow          : status
interface conveng_pixel_server_if;
  import conveng_pixel_server_pkg::*;

  logic                newFrame;
  logic                iValid;
  logic [PixBits-1:0]  iR;
  logic [PixBits-1:0]  iG;
  logic [PixBits-1:0]  iB;
  logic                iReq;
  logic [ReqAddrW-1:0] iRdAddress;
  logic                oReqReady;
  logic [WordBits-1:0] orData;
  logic [WordBits-1:0] ogData;
  logic [WordBits-1:0] obData;
  logic                oRdValid;
  logic                oFrameReady;
  logic                oOverflow;

  modport master (
    output newFrame, iValid, iR, iG, iB, iReq, iRdAddress,
    input  oReqReady, orData, ogData, obData, oRdValid, oFrameReady, oOverflow
  );

  modport slave (
    input  newFrame, iValid, iR, iG, iB, iReq, iRdAddress,
    output oReqReady, orData, ogData, obData, oRdValid, oFrameReady, oOverflow
  );

endinterface

// File: rtl/conveng_req_fifo.sv
// Synchronous request queue with show-ahead head and a flush.
//   clk, reset   : clock, async active-high reset
//   flush        : empty the queue (a same-cycle push lands in the emptied queue)
//   push, wdata  : enqueue (caller guarantees room, or a same-cycle pop)
//   pop          : dequeue the head (ignored when empty)
//   rdata        : current head entry
//   full, empty  : occupancy flags
module conveng_req_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  // Depth is a power of two, so pointers wrap for free.
  localparam int unsigned PtrBits = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]   mem_q [Depth];
  logic [PtrBits-1:0] rptr_q, wptr_q;
  logic [PtrBits:0]   count_q;
  logic               do_pop;
  logic [PtrBits-1:0] wr_idx;

  assign full   = (count_q == (PtrBits + 1)'(Depth));
  assign empty  = (count_q == '0);
  assign rdata  = mem_q[rptr_q];
  assign do_pop = pop && !empty;
  assign wr_idx = flush ? '0 : wptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rptr_q  <= '0;
      wptr_q  <= push ? PtrBits'(1) : '0;
      count_q <= push ? (PtrBits + 1)'(1) : '0;
    end else begin
      if (push)   wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= wdata;
  end

endmodule

// File: rtl/conveng_pixel_server.sv
// Captures an RGB pixel stream into a packed frame buffer (8 pixels per 64-bit word per
// channel) and answers in-order word reads with a fixed 3-edge latency from the pop.
//   clk, reset : clock, async active-high reset
//   bus        : conveng_pixel_server_if.slave (stream in, read requests/responses, status)
module conveng_pixel_server
  import conveng_pixel_server_pkg::*;
#(
  parameter int unsigned width     = 1920,
  parameter int unsigned height    = 1080,
  parameter int unsigned fifoDepth = 4
) (
  input logic                   clk,
  input logic                   reset,
  conveng_pixel_server_if.slave bus
);

  localparam int unsigned FrameWords = width * height / PixPerWord;
  localparam int unsigned AddrBits   = (FrameWords > 1) ? $clog2(FrameWords) : 1;
  localparam int unsigned CntBits    = $clog2(FrameWords + 1);

  state_e               state_q, state_d;
  logic [LaneBits-1:0]  lane_q, lane_d, eff_lane;
  logic [CntBits-1:0]   cnt_q, cnt_d;
  logic                 frame_ready_q, frame_ready_d;
  logic [WordBits-1:0]  asm_r_q, asm_g_q, asm_b_q;
  logic [WordBits-1:0]  asm_r_d, asm_g_d, asm_b_d;
  logic                 overflow_q;
  logic                 live_q;

  logic                 accept, wr_en, last_word;
  logic [AddrBits-1:0]  wr_addr;
  logic [WordBits-1:0]  wr_r, wr_g, wr_b;

  logic                 req_oor, push, pop, fifo_full, fifo_empty, head_oor, head_ok;
  logic [AddrBits:0]    req_word, head;
  logic [AddrBits-1:0]  head_addr;

  logic                 s1_valid_q, s1_oor_q, s2_valid_q, s2_oor_q, rd_valid_q;
  logic [AddrBits-1:0]  s1_addr_q;
  logic [WordBits-1:0]  ram_r_q, ram_g_q, ram_b_q;
  logic [WordBits-1:0]  out_r_q, out_g_q, out_b_q;
  logic [WordBits-1:0]  mem_r [FrameWords];
  logic [WordBits-1:0]  mem_g [FrameWords];
  logic [WordBits-1:0]  mem_b [FrameWords];

  // ---------------- Pixel packing ----------------
  // newFrame restarts packing at lane 0 and takes a same-cycle pixel as the first of the frame.
  assign accept    = bus.iValid && (bus.newFrame || (state_q == StFill));
  assign eff_lane  = bus.newFrame ? '0 : lane_q;
  assign wr_en     = accept && (eff_lane == LaneBits'(PixPerWord - 1));
  assign last_word = (cnt_q == CntBits'(FrameWords - 1));
  assign wr_addr   = cnt_q[AddrBits-1:0];
  assign wr_r      = {bus.iR, asm_r_q[WordBits-PixBits-1:0]};
  assign wr_g      = {bus.iG, asm_g_q[WordBits-PixBits-1:0]};
  assign wr_b      = {bus.iB, asm_b_q[WordBits-PixBits-1:0]};

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    cnt_d         = cnt_q;
    frame_ready_d = frame_ready_q;
    asm_r_d       = asm_r_q;
    asm_g_d       = asm_g_q;
    asm_b_d       = asm_b_q;

    case (state_q)
      StIdle:  ;
      StFill: begin
        if (wr_en && last_word) begin
          state_d       = StReady;
          frame_ready_d = 1'b1;
        end
      end
      StReady: ;
      default: state_d = StIdle;
    endcase

    if (bus.newFrame) begin
      state_d       = StFill;
      lane_d        = '0;
      cnt_d         = '0;
      frame_ready_d = 1'b0;
    end

    if (accept) begin
      asm_r_d = put_lane(asm_r_q, eff_lane, bus.iR);
      asm_g_d = put_lane(asm_g_q, eff_lane, bus.iG);
      asm_b_d = put_lane(asm_b_q, eff_lane, bus.iB);
      lane_d  = eff_lane + 1'b1;
    end

    if (wr_en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      lane_q        <= '0;
      cnt_q         <= '0;
      frame_ready_q <= 1'b0;
      asm_r_q       <= '0;
      asm_g_q       <= '0;
      asm_b_q       <= '0;
      overflow_q    <= 1'b0;
      live_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      cnt_q         <= cnt_d;
      frame_ready_q <= frame_ready_d;
      asm_r_q       <= asm_r_d;
      asm_g_q       <= asm_g_d;
      asm_b_q       <= asm_b_d;
      overflow_q    <= overflow_q | (bus.iReq && !bus.oReqReady);
      live_q        <= 1'b1;
    end
  end

  // ---------------- Request queue ----------------
  assign req_oor   = (bus.iRdAddress >= ReqAddrW'(FrameWords));
  assign req_word  = {req_oor, bus.iRdAddress[AddrBits-1:0]};
  assign head_oor  = head[AddrBits];
  assign head_addr = head[AddrBits-1:0];
  // A word becomes readable the cycle after its counter update; an ineligible head blocks all.
  assign head_ok   = !fifo_empty &&
                     (head_oor || (state_q == StReady) || (CntBits'(head_addr) < cnt_q));
  assign pop       = head_ok;
  // live_q keeps ready low in reset so every output reads 0 there.
  assign bus.oReqReady = live_q && (!fifo_full || pop);
  assign push          = bus.iReq && bus.oReqReady;

  conveng_req_fifo #(
    .Width (AddrBits + 1),
    .Depth (fifoDepth)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.newFrame),
    .push  (push),
    .wdata (req_word),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- Frame RAM and read pipeline ----------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_r;
      mem_g[wr_addr] <= wr_g;
      mem_b[wr_addr] <= wr_b;
    end
    ram_r_q <= mem_r[s1_addr_q];
    ram_g_q <= mem_g[s1_addr_q];
    ram_b_q <= mem_b[s1_addr_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_oor_q   <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_oor_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      out_r_q    <= '0;
      out_g_q    <= '0;
      out_b_q    <= '0;
    end else begin
      s1_valid_q <= pop;
      if (pop) begin
        s1_oor_q  <= head_oor;
        s1_addr_q <= head_addr;
      end
      s2_valid_q <= s1_valid_q;
      s2_oor_q   <= s1_oor_q;
      rd_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_r_q <= s2_oor_q ? '0 : ram_r_q;
        out_g_q <= s2_oor_q ? '0 : ram_g_q;
        out_b_q <= s2_oor_q ? '0 : ram_b_q;
      end
    end
  end

  assign bus.orData      = out_r_q;
  assign bus.ogData      = out_g_q;
  assign bus.obData      = out_b_q;
  assign bus.oRdValid    = rd_valid_q;
  assign bus.oFrameReady = frame_ready_q;
  assign bus.oOverflow   = overflow_q;

endmodule

// File: tb/tb_conveng_pixel_server.sv
// Directed bench for conveng_pixel_server with a 16x4 frame (8 words per channel).
// Pixel n carries R=n, G=n+64, B=n+128.
module tb_conveng_pixel_server;
  import conveng_pixel_server_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;

  conveng_pixel_server_if bus ();

  conveng_pixel_server #(
    .width     (16),
    .height    (4),
    .fifoDepth (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] word_of(input int base);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(base + k);
    return w;
  endfunction

  task automatic stream(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      bus.iValid = 1'b1;
      bus.iR     = 8'(first + i);
      bus.iG     = 8'(first + i + 64);
      bus.iB     = 8'(first + i + 128);
      step();
    end
    bus.iValid = 1'b0;
  endtask

  task automatic request(input logic [31:0] a);
    bus.iReq       = 1'b1;
    bus.iRdAddress = a;
    step();
    bus.iReq       = 1'b0;
  endtask

  // Edges until the next oRdValid pulse; 0 if none within the bound.
  task automatic wait_rd(input int bound, output int lat);
    lat = 0;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (bus.oRdValid && lat == 0) lat = i;
      if (lat != 0) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          np;
    logic        early;
    logic [63:0] er, eg, eb;
    logic [63:0] got_r [3];
    logic [63:0] got_g [3];
    logic [63:0] got_b [3];
    logic [63:0] exp_r [3];
    logic [63:0] exp_g [3];
    logic [63:0] exp_b [3];

    bus.newFrame   = 1'b0;
    bus.iValid     = 1'b0;
    bus.iR         = '0;
    bus.iG         = '0;
    bus.iB         = '0;
    bus.iReq       = 1'b0;
    bus.iRdAddress = '0;
    reset          = 1'b1;
    repeat (3) step();

    // Reset state
    check_eq("rst_ready", bus.oReqReady, 0);
    check_eq("rst_rdvalid", bus.oRdValid, 0);
    check_eq("rst_frame_ready", bus.oFrameReady, 0);
    check_eq("rst_overflow", bus.oOverflow, 0);
    check_eq("rst_rdata", bus.orData | bus.ogData | bus.obData, 0);
    reset = 1'b0;
    step();
    check_eq("ready_after_reset", bus.oReqReady, 1);

    // 1. Full frame, read word 0
    bus.newFrame = 1'b1;
    step();
    bus.newFrame = 1'b0;
    stream(0, 63);
    check_eq("t1_not_ready_at_63", bus.oFrameReady, 0);
    stream(63, 1);
    check_eq("t1_frame_ready", bus.oFrameReady, 1);
    request(0);
    wait_rd(8, lat);
    check_eq("t1_latency", lat, 3);
    check_eq("t1_r", bus.orData, 64'h0706050403020100);
    check_eq("t1_g", bus.ogData, 64'h4746454443424140);
    check_eq("t1_b", bus.obData, 64'h8786858483828180);
    step();
    check_eq("t1_pulse_width", bus.oRdValid, 0);

    // 5. newFrame with a same-cycle pixel from READY
    bus.newFrame = 1'b1;
    bus.iValid   = 1'b1;
    bus.iR       = 8'hAA;
    bus.iG       = 8'hBB;
    bus.iB       = 8'hCC;
    step();
    bus.newFrame = 1'b0;
    bus.iValid   = 1'b0;
    check_eq("t5_frame_ready_cleared", bus.oFrameReady, 0);
    stream(21, 7);
    request(0);
    wait_rd(8, lat);
    check_eq("t5_latency", lat, 3);
    er = word_of(20);
    er[7:0] = 8'hAA;
    eg = word_of(84);
    eg[7:0] = 8'hBB;
    eb = word_of(148);
    eb[7:0] = 8'hCC;
    check_eq("t5_r", bus.orData, er);
    check_eq("t5_g", bus.ogData, eg);
    check_eq("t5_b", bus.obData, eb);

    // 2. Read of a not-yet-written word waits for its write
    bus.newFrame = 1'b1;
    step();
    bus.newFrame = 1'b0;
    stream(0, 16);
    request(3);
    early = 1'b0;
    repeat (4) begin
      step();
      early = early | bus.oRdValid;
    end
    for (int i = 16; i < 32; i++) begin
      stream(i, 1);
      early = early | bus.oRdValid;
    end
    check_eq("t2_no_early_pulse", early, 0);
    wait_rd(8, lat);
    check_eq("t2_latency_from_write", lat, 3);
    check_eq("t2_r", bus.orData, 64'h1F1E1D1C1B1A1918);
    check_eq("t2_g", bus.ogData, word_of(88));

    // 3. Out-of-range reads return zero, in order with an in-range read
    request(8);
    request(0);
    request(32'h0001_0000);
    np = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.oRdValid) begin
        if (np < 3) begin
          got_r[np] = bus.orData;
          got_g[np] = bus.ogData;
          got_b[np] = bus.obData;
        end
        np++;
      end
    end
    exp_r[0] = '0;
    exp_g[0] = '0;
    exp_b[0] = '0;
    exp_r[1] = word_of(0);
    exp_g[1] = word_of(64);
    exp_b[1] = word_of(128);
    exp_r[2] = '0;
    exp_g[2] = '0;
    exp_b[2] = '0;
    check_eq("t3_pulse_count", np, 3);
    if (np == 3) begin
      for (int k = 0; k < 3; k++) begin
        check_eq($sformatf("t3_r%0d", k), got_r[k], exp_r[k]);
        check_eq($sformatf("t3_g%0d", k), got_g[k], exp_g[k]);
        check_eq($sformatf("t3_b%0d", k), got_b[k], exp_b[k]);
      end
    end

    // 4. Blocked head fills the queue; the fifth request is dropped
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t4_ready%0d", k), bus.oReqReady, 1);
      request(6);
    end
    check_eq("t4_full_not_ready", bus.oReqReady, 0);
    check_eq("t4_no_overflow_yet", bus.oOverflow, 0);
    request(6);
    check_eq("t4_overflow", bus.oOverflow, 1);
    repeat (3) step();
    check_eq("t4_overflow_sticky", bus.oOverflow, 1);
    check_eq("t4_still_blocked", bus.oReqReady, 0);

    // 6. Reset one cycle after a pop
    bus.newFrame = 1'b1;
    step();
    bus.newFrame = 1'b0;
    check_eq("t6_flush_ready", bus.oReqReady, 1);
    check_eq("t6_overflow_kept", bus.oOverflow, 1);
    stream(0, 8);
    request(0);
    wait_rd(8, lat);
    check_eq("t6_pre_r", bus.orData, word_of(0));
    request(0);
    step();
    reset = 1'b1;
    #1;
    check_eq("t6_async_r", bus.orData, 0);
    check_eq("t6_async_gb", bus.ogData | bus.obData, 0);
    check_eq("t6_async_overflow", bus.oOverflow, 0);
    check_eq("t6_async_ready", bus.oReqReady, 0);
    check_eq("t6_async_rdvalid", bus.oRdValid, 0);
    repeat (2) step();
    reset = 1'b0;
    early = 1'b0;
    repeat (8) begin
      step();
      early = early | bus.oRdValid;
    end
    check_eq("t6_no_stale_pulse", early, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
